// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - word-addressed data memory with byte-enabled writes and fixed-latency reads
module data_mem_ctrl #(
  parameter int MEM_DEPTH  = 64,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 2,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH),
  localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [BE_WIDTH-1:0]   be,
  output logic                  valid_data,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [15:0]           rd_cnt,
  output logic [15:0]           wr_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = (RD_LATENCY > 1) ? 4'(RD_LATENCY - 2) : 4'd0;

  state_t                  state_q;
  logic [3:0]              cnt_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    req_ready_q;
  logic                    valid_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [15:0]             rd_cnt_q, rd_cnt_d;
  logic [15:0]             wr_cnt_q, wr_cnt_d;
  logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

  logic acc, rd_acc, wr_acc;

  always_comb begin
    acc      = req_valid && req_ready_q;
    rd_acc   = acc && !we;
    wr_acc   = acc && we;
    rd_cnt_d = (rd_acc && rd_cnt_q != 16'hFFFF) ? rd_cnt_q + 16'd1 : rd_cnt_q;
    wr_cnt_d = (wr_acc && wr_cnt_q != 16'hFFFF) ? wr_cnt_q + 16'd1 : wr_cnt_q;
  end

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      req_ready_q <= 1'b0;
      valid_q     <= 1'b0;
      rdata_q     <= '0;
      rd_cnt_q    <= 16'd0;
      wr_cnt_q    <= 16'd0;
    end else begin
      valid_q     <= 1'b0;
      req_ready_q <= 1'b1;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      case (state_q)
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= RESP;
            valid_q <= 1'b1;
            rdata_q <= mem_q[addr_q];
          end else begin
            cnt_q       <= cnt_q - 4'd1;
            req_ready_q <= 1'b0;
          end
        end
        default: begin
          if (rd_acc) begin
            addr_q <= addr;
            // Single-cycle latency samples the array on the accepting edge itself.
            if (RD_LATENCY == 1) begin
              state_q <= RESP;
              valid_q <= 1'b1;
              rdata_q <= mem_q[addr];
            end else begin
              state_q     <= WAIT;
              cnt_q       <= CNT_LOAD;
              req_ready_q <= 1'b0;
            end
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign valid_data = valid_q;
  assign rdata      = rdata_q;
  assign rd_cnt     = rd_cnt_q;
  assign wr_cnt     = wr_cnt_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - self-checking bench for data_mem_ctrl at read latencies 2 and 1
module tb_data_mem_ctrl;

  logic        clk, rst_n, req_valid, we;
  logic [5:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  bit          sel;

  logic        rv_a, rv_b;
  logic        rdy_a, vld_a, rdy_b, vld_b;
  logic [31:0] rd_a, rd_b;
  logic [15:0] rc_a, wc_a, rc_b, wc_b;

  assign rv_a = req_valid & ~sel;
  assign rv_b = req_valid & sel;

  data_mem_ctrl #(.MEM_DEPTH(64), .DATA_WIDTH(32), .RD_LATENCY(2)) u_l2 (
    .clk(clk), .reset(rst_n), .req_valid(rv_a), .req_ready(rdy_a), .we(we), .addr(addr),
    .wdata(wdata), .be(be), .valid_data(vld_a), .rdata(rd_a), .rd_cnt(rc_a), .wr_cnt(wc_a));

  data_mem_ctrl #(.MEM_DEPTH(64), .DATA_WIDTH(32), .RD_LATENCY(1)) u_l1 (
    .clk(clk), .reset(rst_n), .req_valid(rv_b), .req_ready(rdy_b), .we(we), .addr(addr),
    .wdata(wdata), .be(be), .valid_data(vld_b), .rdata(rd_b), .rd_cnt(rc_b), .wr_cnt(wc_b));

  logic        obs_rdy, obs_vld;
  logic [31:0] obs_rd;
  logic [15:0] obs_rc, obs_wc;
  assign obs_rdy = sel ? rdy_b : rdy_a;
  assign obs_vld = sel ? vld_b : vld_a;
  assign obs_rd  = sel ? rd_b  : rd_a;
  assign obs_rc  = sel ? rc_b  : rc_a;
  assign obs_wc  = sel ? wc_b  : wc_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per-instance word array, pending responses with due cycle.
  logic [31:0] mem_m [2][64];
  int          q_due[$];
  logic [31:0] q_data[$];
  logic [15:0] rd_exp [2];
  logic [15:0] wr_exp [2];
  logic [31:0] last_rd [2];
  int          cyc, checks, failures;
  int          last_acc_cyc, last_resp_cyc, prev_acc;
  logic [31:0] last_obs;
  logic        acc_d;

  function automatic int lat();
    return sel ? 1 : 2;
  endfunction

  function automatic logic model_ready();
    return !(q_due.size() > 0 && q_due[0] > cyc);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic ev;
    ev = q_due.size() > 0 && q_due[0] == cyc;
    chk("req_ready", {31'd0, obs_rdy}, {31'd0, model_ready()});
    chk("valid_data", {31'd0, obs_vld}, {31'd0, ev});
    if (obs_vld === 1'b1) begin
      last_resp_cyc = cyc;
      last_obs      = obs_rd;
    end
    if (ev) begin
      last_rd[sel] = q_data.pop_front();
      void'(q_due.pop_front());
    end
    chk("rdata", obs_rd, last_rd[sel]);
    chk("rd_cnt", {16'd0, obs_rc}, {16'd0, rd_exp[sel]});
    chk("wr_cnt", {16'd0, obs_wc}, {16'd0, wr_exp[sel]});
  endtask

  task automatic step(input logic v, input logic w, input logic [5:0] a, input logic [31:0] d,
                      input logic [3:0] b, output logic acc);
    acc = v && model_ready();
    req_valid = v; we = w; addr = a; wdata = d; be = b;
    if (acc) begin
      if (w) begin
        for (int i = 0; i < 4; i++) if (b[i]) mem_m[sel][a][8*i +: 8] = d[8*i +: 8];
        if (wr_exp[sel] != 16'hFFFF) wr_exp[sel]++;
      end else begin
        q_data.push_back(mem_m[sel][a]);
        q_due.push_back(cyc + lat());
        if (rd_exp[sel] != 16'hFFFF) rd_exp[sel]++;
      end
      last_acc_cyc = cyc;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    req_valid = 1'b0;
    check_outputs();
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (q_due.size() > 0 && g < 20) begin
      step(1'b0, 1'b0, 6'd0, 32'd0, 4'd0, acc_d);
      g++;
    end
    chk("drain_timeout", q_due.size(), 0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    req_valid = 1'b0;
    q_due.delete();
    q_data.delete();
    for (int s = 0; s < 2; s++) begin
      rd_exp[s] = 16'd0; wr_exp[s] = 16'd0; last_rd[s] = 32'd0;
    end
    for (int k = 0; k < n; k++) begin
      #1;
      chk("rst_req_ready", {31'd0, obs_rdy}, 32'd0);
      chk("rst_valid", {31'd0, obs_vld}, 32'd0);
      chk("rst_rdata", obs_rd, 32'd0);
      chk("rst_cnts", {obs_rc, obs_wc}, 32'd0);
      @(negedge clk);
      cyc++;
    end
    rst_n = 1'b1;
    step(1'b0, 1'b0, 6'd0, 32'd0, 4'd0, acc_d);
  endtask

  task automatic read_all(input int mult);
    logic acc;
    int   guard;
    for (int a = 0; a < 64; a++) begin
      guard = 0;
      do begin
        step(1'b1, 1'b0, 6'(a), 32'd0, 4'd0, acc);
        guard++;
      end while (!acc && guard < 10);
      chk("rd_accept_timeout", {31'd0, acc}, 32'd1);
      if (a > 0) chk("rd_spacing", last_acc_cyc - prev_acc, lat());
      prev_acc = last_acc_cyc;
    end
    drain();
    if (mult > 0) chk("rd_last_word", last_obs, 32'(63 * mult));
  endtask

  task automatic random_phase(input int n);
    logic [5:0] a;
    for (int i = 0; i < n; i++) begin
      a = 6'($urandom_range(0, 7));
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), acc_d);
    end
    drain();
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; sel = 1'b0;
    rst_n = 1'b0; req_valid = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    last_acc_cyc = 0; last_resp_cyc = 0; prev_acc = 0; last_obs = '0;
    @(negedge clk);
    do_reset(3);

    step(1'b1, 1'b1, 6'd5, 32'hDEADBEEF, 4'hF, acc_d);
    step(1'b1, 1'b0, 6'd5, 32'd0, 4'd0, acc_d);
    drain();
    chk("l2_latency", last_resp_cyc - last_acc_cyc, 2);
    chk("raw_data", last_obs, 32'hDEADBEEF);
    chk("first_cnts", {obs_rc, obs_wc}, {16'd1, 16'd1});

    step(1'b1, 1'b1, 6'd3, 32'h11223344, 4'hF, acc_d);
    step(1'b1, 1'b1, 6'd3, 32'hAABBCCDD, 4'b0101, acc_d);
    step(1'b1, 1'b0, 6'd3, 32'd0, 4'd0, acc_d);
    drain();
    chk("be_merge", last_obs, 32'h11BB33DD);

    for (int a = 0; a < 64; a++) step(1'b1, 1'b1, 6'(a), 32'(a * 3), 4'hF, acc_d);
    read_all(3);

    step(1'b1, 1'b0, 6'd7, 32'd0, 4'd0, acc_d);
    do_reset(2);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 6'd0, 32'd0, 4'd0, acc_d);
    chk("post_reset_rd_cnt", {16'd0, obs_rc}, 32'd0);
    step(1'b1, 1'b0, 6'd7, 32'd0, 4'd0, acc_d);
    drain();
    chk("reread7", last_obs, 32'd21);

    random_phase(200);

    sel = 1'b1;
    for (int a = 0; a < 64; a++) step(1'b1, 1'b1, 6'(a), $urandom, 4'hF, acc_d);
    step(1'b1, 1'b0, 6'd9, 32'd0, 4'd0, acc_d);
    drain();
    chk("l1_latency", last_resp_cyc - last_acc_cyc, 1);
    read_all(0);
    random_phase(200);

    force u_l1.rd_cnt_q = 16'hFFFE;
    #1;
    release u_l1.rd_cnt_q;
    rd_exp[1] = 16'hFFFE;
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 6'(k), 32'd0, 4'd0, acc_d);
    drain();
    chk("rd_cnt_saturate", {16'd0, obs_rc}, 32'h0000FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
